mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM behind a valid/ready request port,
// decoding RISC-V load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW).
//
// Each request walks IDLE -> ACCESS -> RESPOND -> IDLE:
//   IDLE    : req_ready=1, the request is captured on the accepting edge
//   ACCESS  : the RAM word is read on the next edge; a legal store is also
//             written on that edge
//   RESPOND : rsp_valid=1 for one cycle with extended load data or error
//
// Ports
//   clk, reset                 clock, async active-high reset
//   req_valid / req_ready      request handshake
//   req_addr, req_we,          byte address, store flag, width code,
//   req_funct3, req_wdata      right-aligned store data
//   rsp_valid, rsp_rdata,      response strobe, load data, rejection flag
//   rsp_err                    (rdata/err are forced to 0 outside RESPOND)
//   busy                       FSM is not in IDLE
//
// RAM is built as four byte-lane sub-memories so that partial stores only
// enable the lanes they touch. RAM is never cleared by reset.

// One byte lane of the RAM: synchronous read, byte write.
module mem_responder_lane #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           i_rd_en,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [7:0]                     i_wbyte,
    output logic [7:0]                     o_rbyte
);
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_q;

    // Read-before-write; stores return no data, so the old value is harmless.
    always_ff @(posedge clk) begin
        if (i_rd_en) r_q <= r_mem[i_idx];
        if (i_we)    r_mem[i_idx] <= i_wbyte;
    end

    assign o_rbyte = r_q;
endmodule

module mem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    state_t              r_state;
    state_t              w_state_nxt;
    req_t                r_req;

    logic                w_bad_f3;
    logic                w_misalign;
    logic                w_oor;
    logic                w_err;
    logic                w_access;
    logic                w_wr_en;
    logic [AW-1:0]       w_idx;
    logic [3:0]          w_be;
    logic [3:0][7:0]     w_wbytes;
    logic [3:0][7:0]     w_rbytes;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ldata;

    // State register and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && req_valid)
                r_req <= '{addr: req_addr, we: req_we, funct3: req_funct3, wdata: req_wdata};
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) w_state_nxt = ACCESS;
            end
            ACCESS:  w_state_nxt = RESPOND;
            RESPOND: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Legality of the captured request. funct3[1:0] gives the access size
    // for every legal code, so alignment is checked on those bits alone.
    always_comb begin
        if (r_req.we) w_bad_f3 = (r_req.funct3 > 3'b010);
        else          w_bad_f3 = (r_req.funct3 == 3'b011) || (r_req.funct3[2:1] == 2'b11);
        w_misalign = ((r_req.funct3[1:0] == 2'b01) && r_req.addr[0]) ||
                     ((r_req.funct3[1:0] == 2'b10) && (r_req.addr[1:0] != 2'b00));
        w_oor      = (r_req.addr[31:2] >= 30'(DEPTH_WORDS));
        w_err      = w_bad_f3 || w_misalign || w_oor;
    end

    // Store lane enables and replicated write data
    always_comb begin
        w_be     = 4'b0000;
        w_wbytes = r_req.wdata;
        case (r_req.funct3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << r_req.addr[1:0];
                w_wbytes = {4{r_req.wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_req.addr[1] ? 4'b1100 : 4'b0011;
                w_wbytes = {2{r_req.wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_idx    = r_req.addr[AW+1:2];
    assign w_access = (r_state == ACCESS);
    // Gating with reset blocks a store whose ACCESS edge meets reset.
    assign w_wr_en  = w_access && r_req.we && !w_err && !reset;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        mem_responder_lane #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane (
            .clk     (clk),
            .i_rd_en (w_access),
            .i_we    (w_wr_en && w_be[k]),
            .i_idx   (w_idx),
            .i_wbyte (w_wbytes[k]),
            .o_rbyte (w_rbytes[k])
        );
    end

    // Load extraction and extension
    always_comb begin
        w_word = w_rbytes;
        w_byte = w_rbytes[r_req.addr[1:0]];
        w_half = r_req.addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_req.funct3)
            3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
            3'b010:  w_ldata = w_word;
            3'b100:  w_ldata = {24'b0, w_byte};
            3'b101:  w_ldata = {16'b0, w_half};
            default: w_ldata = 32'b0;
        endcase
    end

    // Response data only exists in RESPOND; state resets asynchronously,
    // so these drop to 0 the moment reset rises.
    assign rsp_rdata = (rsp_valid && !w_err && !r_req.we) ? w_ldata : 32'b0;
    assign rsp_err   = rsp_valid && w_err;
endmodule
